// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder
// Instruction-memory responder for the RV32I fetch stage. After reset the
// block sits in LOAD and accepts the program image one word per ld_valid
// beat. The beat flagged ld_last moves it into RUN. In RUN it returns the
// instruction at pc_in one cycle later. It honours stall (hold) and flush
// (NOP bubble), and it flags misaligned or out-of-range fetches.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   pc_in        fetch byte address from the PC unit
//   stall_in     load-use hazard: hold every fetch output
//   flush_in     redirect: replace the fetched word with a bubble
//   ld_valid     image load word present
//   ld_data      image load word
//   ld_last      with ld_valid: final word of the image
//   ld_ready     high while in LOAD
//   ld_overflow  sticky: a load word was dropped because the image is too big
//   instr_out    fetched instruction (NOP_WORD when a bubble)
//   instr_pc_out byte address that instr_out belongs to
//   instr_valid  instr_out is a real fetched instruction
//   addr_fault   instr_out is a bubble caused by a bad pc_in
module imem_fetch_responder #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        ld_overflow,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc_out,
  output logic        instr_valid,
  output logic        addr_fault
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    LOAD,
    RUN
  } state_t;

  state_t state;
  state_t state_next;

  // One extra bit so the pointer can hold DEPTH itself: the top bit set means
  // the array is full and further load words are dropped.
  logic [ADDR_W:0]   wr_ptr;
  logic [31:0]       mem [DEPTH];

  logic              mem_full;
  logic              load_beat;
  logic              pc_fault;
  logic [ADDR_W-1:0] rd_idx;

  logic [31:0]       instr_next;
  logic [31:0]       instr_pc_next;
  logic              instr_valid_next;
  logic              addr_fault_next;

  assign mem_full  = wr_ptr[ADDR_W];
  assign load_beat = (state == LOAD) && ld_valid;
  assign ld_ready  = (state == LOAD);
  assign rd_idx    = pc_in[ADDR_W+1:2];

  // A fetch is bad if it is not word aligned or if it addresses beyond the array.
  assign pc_fault  = (pc_in[1:0] != 2'b00) || (pc_in[31:ADDR_W+2] != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // RUN is left only through reset.
  always_comb begin
    state_next = state;
    if (load_beat && ld_last) begin
      state_next = RUN;
    end
  end

  // The write pointer saturates at DEPTH. Words arriving after that are
  // dropped and latch the overflow flag, which only reset clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      ld_overflow <= 1'b0;
    end else if (load_beat) begin
      if (!mem_full) begin
        wr_ptr <= wr_ptr + {{ADDR_W{1'b0}}, 1'b1};
      end else begin
        ld_overflow <= 1'b1;
      end
    end
  end

  // The memory has no reset. A reload after reset overwrites the old image
  // from word 0 upward and leaves the higher words intact.
  always_ff @(posedge clk) begin
    if (!rst && load_beat && !mem_full) begin
      mem[wr_ptr[ADDR_W-1:0]] <= ld_data;
    end
  end

  // Fetch priority in RUN: flush, then stall, then address fault, then normal
  // fetch. In LOAD the outputs keep the values that reset gave them.
  always_comb begin
    instr_next       = instr_out;
    instr_pc_next    = instr_pc_out;
    instr_valid_next = instr_valid;
    addr_fault_next  = addr_fault;
    if (state == RUN) begin
      if (flush_in) begin
        instr_next       = NOP_WORD;
        instr_pc_next    = pc_in;
        instr_valid_next = 1'b0;
        addr_fault_next  = 1'b0;
      end else if (!stall_in) begin
        instr_pc_next = pc_in;
        if (pc_fault) begin
          instr_next       = NOP_WORD;
          instr_valid_next = 1'b0;
          addr_fault_next  = 1'b1;
        end else begin
          instr_next       = mem[rd_idx];
          instr_valid_next = 1'b1;
          addr_fault_next  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_out    <= NOP_WORD;
      instr_pc_out <= '0;
      instr_valid  <= 1'b0;
      addr_fault   <= 1'b0;
    end else begin
      instr_out    <= instr_next;
      instr_pc_out <= instr_pc_next;
      instr_valid  <= instr_valid_next;
      addr_fault   <= addr_fault_next;
    end
  end

endmodule
